hssl_link_sequencer: RTL and testbench
======================================

// Module: hssl_link_sequencer
// PURPOSE
//  Bring-up and supervision controller for the HSSL gigabit transceiver block (GTP/GTH).
//  Runs on the free-running clock. Drives the transceiver reset inputs (reset-all, TX
//  datapath, RX datapath) and TX electrical idle, and synchronises the transceiver status.
//  Declares link-up once the receiver detects commas, and recovers from receive errors by
//  RX datapath resets, escalating to a full reset.
// PARAMETERS
//  RST_CYCLES    16       cycles each reset output is held asserted (>=1)
//  TMO_CYCLES    1048576  max cycles waited for any status before timeout (<2^TIMER_W)
//  ERR_WINDOW    4096     error-monitor window length in cycles
//  ERR_THRESH    16       error cycles per window that trigger recovery (1..ERR_WINDOW)
//  MAX_RX_RETRY  3        consecutive RX-only recoveries before a full reset
//  TIMER_W       24       width of the shared wait/pulse timer
// PORTS
//  clk_in                  in   1  free-running clock (all logic)
//  reset_n_in              in   1  synchronous, active-low reset
//  tx_usrclk_active_in     in   1  async; TX user clock running
//  tx_reset_done_in        in   1  async; TX reset complete
//  rx_reset_done_in        in   1  async; RX reset complete
//  rx_commadet_in          in   1  async level; comma seen (stretched upstream)
//  rx_error_in             in   1  async level; OR of disperr/encerr/bufstatus (stretched)
//  reset_all_out           out  1  to transceiver reset_all
//  tx_reset_datapath_out   out  1  to transceiver TX datapath reset
//  rx_reset_datapath_out   out  1  to transceiver RX datapath reset
//  tx_elecidle_out         out  1  TX electrical idle
//  link_up_out             out  1  link usable
//  state_out               out  3  current FSM state code
//  retry_cnt_out           out  8  total recoveries since reset, saturating at 255
// BEHAVIOUR
//  - Reset (reset_n_in=0 at clk edge) sets outputs and counters:
//    - reset_all_out=1, tx_elecidle_out=1.
//    - All other outputs 0; state=RST_ALL; timer, window and retry counters 0.
//    - Asserting reset mid-sequence aborts any state immediately.
//  - All async inputs pass through a 2-FF synchroniser. FSM sees them 2 cycles late.
//  - States and codes:
//    - RST_ALL=0: reset_all_out=1 for RST_CYCLES cycles, then WAIT_CLK.
//    - WAIT_CLK=1: wait for tx_usrclk_active.
//    - TX_RST=2: tx_reset_datapath_out=1 for RST_CYCLES, then wait for tx_reset_done.
//      On done: tx_elecidle_out<=0, then go to RX_RST.
//    - RX_RST=3: rx_reset_datapath_out=1 for RST_CYCLES, then wait for rx_reset_done,
//      then go to ALIGN.
//    - ALIGN=4: wait for rx_commadet sync=1 for 8 consecutive cycles, then go to LINK_UP.
//      Window and error count are cleared on entry.
//    - LINK_UP=5: link_up_out=1, registered and asserted on the first cycle in the state.
//  - Timeout applies in states 1-4: timer reaching TMO_CYCLES-1 -> RST_ALL, tx_elecidle_out<=1.
//  - Reset pulse outputs deassert on the cycle the timer reaches RST_CYCLES.
//  - Every state transition clears the timer.
//  - Error monitor in LINK_UP:
//    - Count cycles with rx_error sync=1 (saturating) over ERR_WINDOW-cycle windows.
//    - If count reaches ERR_THRESH: link_up_out<=0 next cycle and go to RX_RST, or to
//      RST_ALL if the consecutive-retry count equals MAX_RX_RETRY.
//    - Window end with no trigger: clear error count and consecutive-retry count.
//    - An error on the window's last cycle counts toward the closing window; the threshold
//      check includes that cycle.
//  - If rx_reset_done or tx_usrclk_active drops while in LINK_UP: immediate recovery as above,
//    same retry rules. A tx_usrclk_active loss always goes to RST_ALL.
//  - retry_cnt_out increments on every recovery entry to RX_RST or RST_ALL from LINK_UP,
//    and on timeouts.
//  - Power-up entry to RST_ALL does not count.
// STRUCTURE
//  - Shared header: state code defines (width 3), default timing parameters.
//  - Sub-module hssl_status_sync: parameterised N-bit 2-FF synchroniser.
//    - Instantiated once with N=5.
//    - ASYNC_REG attributes are placed on the synchroniser flops.
//  - One FSM, one shared TIMER_W timer, window counter, error counter, retry counters.
// TESTING (RST_CYCLES=4, TMO_CYCLES=64, ERR_WINDOW=32, ERR_THRESH=4, MAX_RX_RETRY=2)
//  1. Clean bring-up:
//     - Stimulus: all status inputs rise promptly.
//     - Response: reset_all_out high 4 cycles, then tx then rx reset pulses of 4 cycles.
//       link_up_out=1 exactly 8+2 cycles after commadet rises; retry_cnt_out=0.
//  2. Timeout:
//     - Stimulus: tx_reset_done_in held 0.
//     - Response: after 64 cycles in TX_RST, state_out=0, tx_elecidle_out=1,
//       retry_cnt_out=1; sequence restarts.
//  3. Sub-threshold errors:
//     - Stimulus: 3 error cycles per 32-cycle window for 10 windows.
//     - Response: link_up_out stays 1, retry_cnt_out=0.
//  4. Escalation:
//     - Stimulus: 4 error cycles per window, with ALIGN re-entered each time.
//     - Response: two recoveries to RX_RST (state_out=3), the third goes to RST_ALL (0);
//       retry_cnt_out=3.
//  5. Boundary error:
//     - Stimulus: 3 errors early in the window plus 1 on the last window cycle.
//     - Response: recovery fires, and the next window starts at count 0.
//  6. Mid-operation reset and status loss:
//     - Stimulus: reset_n_in=0 for 1 cycle in LINK_UP.
//       Separately, drop rx_reset_done_in in LINK_UP.
//     - Response: outputs return to reset values next cycle, counters 0.
//       Loss of rx_reset_done -> RX_RST with retry_cnt_out+1.

Source files
------------

// File: rtl/hssl_link_sequencer_pkg.sv
// Shared definitions for the HSSL link sequencer: state codes, default timing
// and the bit map of the synchronised transceiver status vector.
package hssl_link_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RST_ALL  = 3'd0,
        ST_WAIT_CLK = 3'd1,
        ST_TX_RST   = 3'd2,
        ST_RX_RST   = 3'd3,
        ST_ALIGN    = 3'd4,
        ST_LINK_UP  = 3'd5
    } link_state_t;

    localparam int DEF_RST_CYCLES   = 16;
    localparam int DEF_TMO_CYCLES   = 1048576;
    localparam int DEF_ERR_WINDOW   = 4096;
    localparam int DEF_ERR_THRESH   = 16;
    localparam int DEF_MAX_RX_RETRY = 3;
    localparam int DEF_TIMER_W      = 24;

    localparam int ALIGN_COMMAS = 8;

    localparam int SYNC_W       = 5;
    localparam int SYNC_USRCLK  = 0;
    localparam int SYNC_TX_DONE = 1;
    localparam int SYNC_RX_DONE = 2;
    localparam int SYNC_COMMA   = 3;
    localparam int SYNC_ERROR   = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/hssl_status_sync.sv
// N-bit two-flop synchroniser for transceiver status levels crossing into the
// free-running clock domain.
module hssl_status_sync #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic [N-1:0] async_bits,
    output logic [N-1:0] sync_bits
);

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [N-1:0] stable;

    always_ff @(posedge clk) begin
        meta   <= async_bits;
        stable <= meta;
    end

    assign sync_bits = stable;

endmodule

// File: rtl/hssl_link_sequencer.sv
// Bring-up and supervision FSM for the HSSL transceiver: sequences the resets,
// waits for alignment, then watches receive errors and status loss.
module hssl_link_sequencer
    import hssl_link_sequencer_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int TMO_CYCLES   = DEF_TMO_CYCLES,
    parameter int ERR_WINDOW   = DEF_ERR_WINDOW,
    parameter int ERR_THRESH   = DEF_ERR_THRESH,
    parameter int MAX_RX_RETRY = DEF_MAX_RX_RETRY,
    parameter int TIMER_W      = DEF_TIMER_W
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic       tx_usrclk_active_in,
    input  logic       tx_reset_done_in,
    input  logic       rx_reset_done_in,
    input  logic       rx_commadet_in,
    input  logic       rx_error_in,
    output logic       reset_all_out,
    output logic       tx_reset_datapath_out,
    output logic       rx_reset_datapath_out,
    output logic       tx_elecidle_out,
    output logic       link_up_out,
    output logic [2:0] state_out,
    output logic [7:0] retry_cnt_out
);

    localparam int WIN_W = $clog2(ERR_WINDOW + 1);
    localparam int ERR_W = $clog2(ERR_THRESH + 1);

    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RST_DONE    = TIMER_W'(RST_CYCLES);
    localparam logic [TIMER_W-1:0] TMO_LAST    = TIMER_W'(TMO_CYCLES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(ERR_WINDOW - 1);
    localparam logic [ERR_W-1:0]   ERR_LIMIT   = ERR_W'(ERR_THRESH);
    localparam logic [7:0]         RETRY_LIMIT = 8'(MAX_RX_RETRY);
    localparam logic [3:0]         COMMA_LAST  = 4'(ALIGN_COMMAS - 1);

    logic [SYNC_W-1:0] status_sync;
    logic usrclk_ok, tx_done, rx_done, comma_seen, rx_err;

    link_state_t state, state_d;
    logic [TIMER_W-1:0] timer, timer_d;
    logic [WIN_W-1:0]   win_cnt, win_d;
    logic [ERR_W-1:0]   err_cnt, err_d, err_next;
    logic [7:0]         consec_cnt, consec_d;
    logic [7:0]         retry_cnt, retry_d;
    logic [3:0]         comma_cnt, comma_d;
    logic reset_all_q, reset_all_d;
    logic tx_rst_q, tx_rst_d;
    logic rx_rst_q, rx_rst_d;
    logic elecidle_q, elecidle_d;
    logic link_up_q, link_up_d;

    hssl_status_sync #(
        .N (SYNC_W)
    ) u_status_sync (
        .clk        (clk_in),
        .async_bits ({rx_error_in, rx_commadet_in, rx_reset_done_in,
                      tx_reset_done_in, tx_usrclk_active_in}),
        .sync_bits  (status_sync)
    );

    assign usrclk_ok  = status_sync[SYNC_USRCLK];
    assign tx_done    = status_sync[SYNC_TX_DONE];
    assign rx_done    = status_sync[SYNC_RX_DONE];
    assign comma_seen = status_sync[SYNC_COMMA];
    assign rx_err     = status_sync[SYNC_ERROR];

    // Includes the current cycle so an error on the window's last cycle still triggers.
    assign err_next = (rx_err && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state       <= ST_RST_ALL;
            timer       <= '0;
            win_cnt     <= '0;
            err_cnt     <= '0;
            consec_cnt  <= '0;
            retry_cnt   <= '0;
            comma_cnt   <= '0;
            reset_all_q <= 1'b1;
            tx_rst_q    <= 1'b0;
            rx_rst_q    <= 1'b0;
            elecidle_q  <= 1'b1;
            link_up_q   <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            win_cnt     <= win_d;
            err_cnt     <= err_d;
            consec_cnt  <= consec_d;
            retry_cnt   <= retry_d;
            comma_cnt   <= comma_d;
            reset_all_q <= reset_all_d;
            tx_rst_q    <= tx_rst_d;
            rx_rst_q    <= rx_rst_d;
            elecidle_q  <= elecidle_d;
            link_up_q   <= link_up_d;
        end
    end

    always_comb begin
        state_d     = state;
        timer_d     = timer + 1'b1;
        win_d       = win_cnt;
        err_d       = err_cnt;
        consec_d    = consec_cnt;
        retry_d     = retry_cnt;
        comma_d     = comma_cnt;
        reset_all_d = reset_all_q;
        tx_rst_d    = tx_rst_q;
        rx_rst_d    = rx_rst_q;
        elecidle_d  = elecidle_q;
        link_up_d   = link_up_q;

        case (state)
            ST_RST_ALL: begin
                if (timer == RST_LAST) begin
                    state_d     = ST_WAIT_CLK;
                    timer_d     = '0;
                    reset_all_d = 1'b0;
                end
            end
            ST_WAIT_CLK: begin
                if (usrclk_ok) begin
                    state_d  = ST_TX_RST;
                    timer_d  = '0;
                    tx_rst_d = 1'b1;
                end
            end
            ST_TX_RST: begin
                if (timer == RST_LAST) begin
                    tx_rst_d = 1'b0;
                end
                if (timer >= RST_DONE && tx_done) begin
                    state_d    = ST_RX_RST;
                    timer_d    = '0;
                    elecidle_d = 1'b0;
                    rx_rst_d   = 1'b1;
                end
            end
            ST_RX_RST: begin
                if (timer == RST_LAST) begin
                    rx_rst_d = 1'b0;
                end
                if (timer >= RST_DONE && rx_done) begin
                    state_d = ST_ALIGN;
                    timer_d = '0;
                    win_d   = '0;
                    err_d   = '0;
                    comma_d = '0;
                end
            end
            ST_ALIGN: begin
                if (!comma_seen) begin
                    comma_d = '0;
                end else if (comma_cnt == COMMA_LAST) begin
                    state_d   = ST_LINK_UP;
                    timer_d   = '0;
                    link_up_d = 1'b1;
                end else begin
                    comma_d = comma_cnt + 1'b1;
                end
            end
            ST_LINK_UP: begin
                timer_d = '0;
                win_d   = (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
                err_d   = err_next;
                if (!usrclk_ok || !rx_done || (err_next >= ERR_LIMIT)) begin
                    link_up_d = 1'b0;
                    retry_d   = sat_inc8(retry_cnt);
                    // Losing the user clock means the TX side is gone too, so only a full reset helps.
                    if (!usrclk_ok || (consec_cnt == RETRY_LIMIT)) begin
                        state_d     = ST_RST_ALL;
                        reset_all_d = 1'b1;
                        elecidle_d  = 1'b1;
                        consec_d    = '0;
                    end else begin
                        state_d  = ST_RX_RST;
                        rx_rst_d = 1'b1;
                        consec_d = consec_cnt + 1'b1;
                    end
                end else if (win_cnt == WIN_LAST) begin
                    err_d    = '0;
                    consec_d = '0;
                end
            end
            default: begin
                state_d     = ST_RST_ALL;
                timer_d     = '0;
                reset_all_d = 1'b1;
                tx_rst_d    = 1'b0;
                rx_rst_d    = 1'b0;
                elecidle_d  = 1'b1;
                link_up_d   = 1'b0;
            end
        endcase

        // A state that made progress this cycle is not timed out.
        if ((state inside {ST_WAIT_CLK, ST_TX_RST, ST_RX_RST, ST_ALIGN}) &&
            (state_d == state) && (timer == TMO_LAST)) begin
            state_d     = ST_RST_ALL;
            timer_d     = '0;
            reset_all_d = 1'b1;
            tx_rst_d    = 1'b0;
            rx_rst_d    = 1'b0;
            elecidle_d  = 1'b1;
            consec_d    = '0;
            comma_d     = '0;
            retry_d     = sat_inc8(retry_cnt);
        end
    end

    assign reset_all_out         = reset_all_q;
    assign tx_reset_datapath_out = tx_rst_q;
    assign rx_reset_datapath_out = rx_rst_q;
    assign tx_elecidle_out       = elecidle_q;
    assign link_up_out           = link_up_q;
    assign state_out             = state;
    assign retry_cnt_out         = retry_cnt;

endmodule

// File: tb/tb_hssl_link_sequencer.sv
// Directed self-checking bench for hssl_link_sequencer using short timing
// parameters so every bring-up, timeout and recovery path runs in a few hundred cycles.
module tb_hssl_link_sequencer;

    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic       tx_usrclk_active_in = 1'b0;
    logic       tx_reset_done_in = 1'b0;
    logic       rx_reset_done_in = 1'b0;
    logic       rx_commadet_in = 1'b0;
    logic       rx_error_in = 1'b0;
    logic       reset_all_out;
    logic       tx_reset_datapath_out;
    logic       rx_reset_datapath_out;
    logic       tx_elecidle_out;
    logic       link_up_out;
    logic [2:0] state_out;
    logic [7:0] retry_cnt_out;

    int checks = 0;
    int errors = 0;

    hssl_link_sequencer #(
        .RST_CYCLES   (4),
        .TMO_CYCLES   (64),
        .ERR_WINDOW   (32),
        .ERR_THRESH   (4),
        .MAX_RX_RETRY (2),
        .TIMER_W      (24)
    ) dut (
        .clk_in                (clk_in),
        .reset_n_in            (reset_n_in),
        .tx_usrclk_active_in   (tx_usrclk_active_in),
        .tx_reset_done_in      (tx_reset_done_in),
        .rx_reset_done_in      (rx_reset_done_in),
        .rx_commadet_in        (rx_commadet_in),
        .rx_error_in           (rx_error_in),
        .reset_all_out         (reset_all_out),
        .tx_reset_datapath_out (tx_reset_datapath_out),
        .rx_reset_datapath_out (rx_reset_datapath_out),
        .tx_elecidle_out       (tx_elecidle_out),
        .link_up_out           (link_up_out),
        .state_out             (state_out),
        .retry_cnt_out         (retry_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic usrclk, input logic tx_done, input logic rx_done,
                                 input logic comma, input logic err);
        tx_usrclk_active_in = usrclk;
        tx_reset_done_in    = tx_done;
        rx_reset_done_in    = rx_done;
        rx_commadet_in      = comma;
        rx_error_in         = err;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic waitState(input logic [2:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && state_out !== target; i++) tick(1);
        checkOutput(tag, 8'(state_out), 8'(target));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".reset_all"}, 8'(reset_all_out), 8'd1);
        checkOutput({tag, ".elecidle"}, 8'(tx_elecidle_out), 8'd1);
        checkOutput({tag, ".tx_rst"}, 8'(tx_reset_datapath_out), 8'd0);
        checkOutput({tag, ".rx_rst"}, 8'(rx_reset_datapath_out), 8'd0);
        checkOutput({tag, ".link_up"}, 8'(link_up_out), 8'd0);
        checkOutput({tag, ".state"}, 8'(state_out), 8'd0);
        checkOutput({tag, ".retry"}, retry_cnt_out, 8'd0);
    endtask

    initial begin
        $display("[TB] start");

        // Power-up reset with every status already good.
        reset_n_in = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(3);
        checkResetValues("por");

        // Clean bring-up with exact pulse timing.
        reset_n_in = 1'b1;
        tick(3);
        checkOutput("t1.rst_all_e3", 8'(reset_all_out), 8'd1);
        tick(1);
        checkOutput("t1.rst_all_e4", 8'(reset_all_out), 8'd0);
        checkOutput("t1.wait_clk", 8'(state_out), 8'd1);
        tick(1);
        checkOutput("t1.tx_state", 8'(state_out), 8'd2);
        checkOutput("t1.tx_rst_on", 8'(tx_reset_datapath_out), 8'd1);
        tick(3);
        checkOutput("t1.tx_rst_e8", 8'(tx_reset_datapath_out), 8'd1);
        tick(1);
        checkOutput("t1.tx_rst_off", 8'(tx_reset_datapath_out), 8'd0);
        checkOutput("t1.idle_held", 8'(tx_elecidle_out), 8'd1);
        tick(1);
        checkOutput("t1.rx_state", 8'(state_out), 8'd3);
        checkOutput("t1.rx_rst_on", 8'(rx_reset_datapath_out), 8'd1);
        checkOutput("t1.idle_off", 8'(tx_elecidle_out), 8'd0);
        tick(4);
        checkOutput("t1.rx_rst_off", 8'(rx_reset_datapath_out), 8'd0);
        tick(1);
        checkOutput("t1.align", 8'(state_out), 8'd4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(9);
        checkOutput("t1.link_early", 8'(link_up_out), 8'd0);
        tick(1);
        checkOutput("t1.link_up", 8'(link_up_out), 8'd1);
        checkOutput("t1.link_state", 8'(state_out), 8'd5);
        checkOutput("t1.retry", retry_cnt_out, 8'd0);

        // Three error cycles per window for ten windows stays below threshold.
        for (int w = 0; w < 10; w++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            tick(3);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            tick(29);
        end
        checkOutput("t3.link_up", 8'(link_up_out), 8'd1);
        checkOutput("t3.state", 8'(state_out), 8'd5);
        checkOutput("t3.retry", retry_cnt_out, 8'd0);

        // Three early errors plus one counted on the window's last cycle.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(26);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("t5.before_last", 8'(state_out), 8'd5);
        tick(1);
        checkOutput("t5.recover", 8'(state_out), 8'd3);
        checkOutput("t5.link_down", 8'(link_up_out), 8'd0);
        checkOutput("t5.rx_rst", 8'(rx_reset_datapath_out), 8'd1);
        checkOutput("t5.retry", retry_cnt_out, 8'd1);
        waitState(3'd5, 40, "t5.relink");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(40);
        checkOutput("t5.fresh_window", 8'(state_out), 8'd5);
        checkOutput("t5.retry_kept", retry_cnt_out, 8'd1);

        // One-cycle reset while linked clears everything.
        reset_n_in = 1'b0;
        tick(1);
        checkResetValues("t6.reset");
        reset_n_in = 1'b1;
        waitState(3'd5, 60, "t6.relink");

        // Escalation: two RX-only recoveries, then a full reset.
        for (int r = 1; r <= 2; r++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            tick(4);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            waitState(3'd3, 8, "t4.rx_recover");
            checkOutput("t4.rx_retry", retry_cnt_out, 8'(r));
            waitState(3'd5, 40, "t4.realign");
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(4);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        waitState(3'd0, 8, "t4.full_reset");
        checkOutput("t4.retry", retry_cnt_out, 8'd3);
        checkOutput("t4.idle", 8'(tx_elecidle_out), 8'd1);
        checkOutput("t4.reset_all", 8'(reset_all_out), 8'd1);
        checkOutput("t4.link_down", 8'(link_up_out), 8'd0);
        waitState(3'd5, 60, "t4.relink");
        checkOutput("t4.retry_kept", retry_cnt_out, 8'd3);

        // Timeout waiting for TX reset done.
        reset_n_in = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        checkOutput("t2.reset_retry", retry_cnt_out, 8'd0);
        reset_n_in = 1'b1;
        waitState(3'd2, 10, "t2.tx_state");
        tick(63);
        checkOutput("t2.still_tx", 8'(state_out), 8'd2);
        tick(1);
        checkOutput("t2.timeout", 8'(state_out), 8'd0);
        checkOutput("t2.idle", 8'(tx_elecidle_out), 8'd1);
        checkOutput("t2.reset_all", 8'(reset_all_out), 8'd1);
        checkOutput("t2.retry", retry_cnt_out, 8'd1);
        tick(5);
        checkOutput("t2.restart", 8'(state_out), 8'd2);
        checkOutput("t2.restart_pulse", 8'(tx_reset_datapath_out), 8'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        waitState(3'd5, 40, "t2.relink");
        checkOutput("t2.retry_kept", retry_cnt_out, 8'd1);

        // Loss of RX reset done while linked.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(2);
        checkOutput("t6.rx_loss_sync", 8'(state_out), 8'd5);
        tick(1);
        checkOutput("t6.rx_loss", 8'(state_out), 8'd3);
        checkOutput("t6.rx_loss_link", 8'(link_up_out), 8'd0);
        checkOutput("t6.rx_loss_retry", retry_cnt_out, 8'd2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        waitState(3'd5, 40, "t6.rx_relink");

        // Loss of the TX user clock always forces a full reset.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(3);
        checkOutput("t6.clk_loss", 8'(state_out), 8'd0);
        checkOutput("t6.clk_loss_idle", 8'(tx_elecidle_out), 8'd1);
        checkOutput("t6.clk_loss_retry", retry_cnt_out, 8'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        waitState(3'd5, 60, "t6.clk_relink");
        checkOutput("t6.final_link", 8'(link_up_out), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
